temp_status_controller: RTL and testbench
=========================================

TEMP_STATUS_CONTROLLER -- requirements
Module: temp_status_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, max clk cycles between temp_valid strobes before error.
REQ-002 SHALL have parameter DWELL_CYCLES, default 50_000_000, minimum clk cycles in a state before a non-error transition.
REQ-003 SHALL have parameter HYST, default 2, hysteresis in degrees C.
REQ-004 SHALL have parameters TEMP_MIN, default 0, and TEMP_MAX, default 100, the plausible sample range in degrees C inclusive.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic clocked on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port temp_valid, input, 1, single-cycle strobe marking temp_data valid.
REQ-008 SHALL have port temp_data, input, 8, unsigned temperature sample in degrees C.
REQ-009 SHALL have port heat_setpoint, input, 8, unsigned; heating starts below it.
REQ-010 SHALL have port cool_setpoint, input, 8, unsigned; cooling starts above it.
REQ-011 SHALL have port status, output, 2: 00 idle, 01 heating, 10 cooling, 11 error; this is the status input encoding of the display block.
REQ-012 SHALL have ports heater_en and cooler_en, outputs, 1 each, actuator enables.

Function
REQ-013 SHALL implement the registered FSM IDLE, HEATING, COOLING, ERROR; status SHALL be the state encoding per REQ-011.
REQ-014 SHALL evaluate a sample only in cycles with temp_valid=1; status, heater_en and cooler_en SHALL update on the next rising edge, giving 1-cycle latency.
REQ-015 SHALL treat a sample as good if TEMP_MIN <= temp_data <= TEMP_MAX and heat_setpoint < cool_setpoint; otherwise it is bad.
REQ-016 SHALL enter ERROR from any state on a bad sample.
REQ-017 SHALL, with a good sample in IDLE: go to HEATING if temp_data < heat_setpoint; else go to COOLING if temp_data > cool_setpoint; else stay in IDLE.
REQ-018 SHALL, with a good sample, leave HEATING for IDLE when temp_data >= heat_setpoint + HYST, computed 9-bit with no wrap.
REQ-019 SHALL, with a good sample, leave COOLING for IDLE when temp_data <= cool_setpoint - HYST, computed so it saturates at 0.
REQ-020 SHALL move from ERROR to IDLE only on a good sample, never directly to HEATING or COOLING.
REQ-021 SHALL keep a timeout counter, cleared on every temp_valid, that otherwise increments; it SHALL force ERROR when it reaches TIMEOUT_CYCLES-1 and then hold at that value.
REQ-022 SHALL, when temp_valid arrives in the same cycle as timeout expiry, evaluate the sample and not apply the timeout.
REQ-023 SHALL drive heater_en=1 only in HEATING and cooler_en=1 only in COOLING, both registered; they SHALL never be 1 together.
REQ-024 SHALL set both enables to 0 in ERROR and IDLE.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, set state IDLE, status=00, heater_en=0, cooler_en=0, and clear the timeout and dwell counters.
REQ-026 SHALL give reset priority over temp_valid, and SHALL abort any transition in progress or dwell in progress with no pending effect.

Configuration
REQ-027 SHALL use macro TEMP_DWELL_EN to compile in minimum-dwell enforcement.
REQ-028 SHALL, when TEMP_DWELL_EN is defined, keep a dwell counter cleared on every state change that saturates at DWELL_CYCLES.
REQ-029 SHALL, when TEMP_DWELL_EN is defined, evaluate a good sample arriving before the dwell counter reaches DWELL_CYCLES and then discard it, with no transition and nothing queued; ERROR entry SHALL ignore dwell.
REQ-030 SHALL, when TEMP_DWELL_EN is undefined, omit the dwell counter entirely and take transitions immediately per REQ-017 to REQ-020.

Verification
Bench parameters: TIMEOUT_CYCLES=20, DWELL_CYCLES=10, HYST=2; setpoints heat=20, cool=25.
REQ-031 SHALL cover: reset, then a sample of 18 -> next cycle status=01, heater_en=1; then a sample of 21 -> stays 01; then 22 -> status=00, heater_en=0.
REQ-032 SHALL cover: from IDLE, a sample of 27 -> status=10, cooler_en=1; then 24 -> stays 10; then 23 -> status=00.
REQ-033 SHALL cover: no temp_valid for 20 cycles -> status=11 with both enables 0; then a good sample of 22 -> status=00.
REQ-034 SHALL cover: a sample of 101, or setpoints heat=25 with cool=25 -> status=11 the next cycle from any state.
REQ-035 SHALL cover: with TEMP_DWELL_EN defined, enter HEATING, then a sample of 30 at 3 cycles after entry -> stays 01; the same sample after 10 cycles -> 00. Without the macro, the sample at 3 cycles -> 00.
REQ-036 SHALL cover: temp_valid in the exact expiry cycle with a sample of 22 -> no ERROR; and reset asserted in the same cycle as a sample of 18 -> status=00.

Source files
------------

// File: rtl/temp_status_controller.sv
// rtl/temp_status_controller.sv - temperature status FSM with sample timeout and optional minimum dwell (TEMP_DWELL_EN)
module temp_status_controller #(
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int DWELL_CYCLES   = 50_000_000,
    parameter int HYST           = 2,
    parameter int TEMP_MIN       = 0,
    parameter int TEMP_MAX       = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       temp_valid,
    input  logic [7:0] temp_data,
    input  logic [7:0] heat_setpoint,
    input  logic [7:0] cool_setpoint,
    output logic [1:0] status,
    output logic       heater_en,
    output logic       cooler_en
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEATING = 2'b01,
        COOLING = 2'b10,
        ERROR   = 2'b11
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [8:0]        HYST9 = 9'(HYST);
    localparam logic signed [9:0] MIN_S = 10'(TEMP_MIN);
    localparam logic signed [9:0] MAX_S = 10'(TEMP_MAX);

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] tcnt;
    logic          dwell_ok;

    logic              good;
    logic signed [9:0] temp_s;
    logic [8:0]        temp9;
    logic [8:0]        heat_thr;
    logic [8:0]        cool_thr;

    // Range check done signed so a TEMP_MIN of 0 is still a meaningful compare
    assign temp_s = signed'({2'b00, temp_data});
    assign temp9  = {1'b0, temp_data};
    assign good   = (temp_s >= MIN_S) && (temp_s <= MAX_S) && (heat_setpoint < cool_setpoint);

    // Exit thresholds: heating side widened to 9 bits, cooling side floored at 0
    always_comb begin
        heat_thr = {1'b0, heat_setpoint} + HYST9;
        cool_thr = 9'd0;
        if ({1'b0, cool_setpoint} > HYST9)
            cool_thr = {1'b0, cool_setpoint} - HYST9;
    end

`ifdef TEMP_DWELL_EN
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DWELL_CYCLES);

    logic [DW-1:0] dcnt;

    assign dwell_ok = (dcnt == D_LAST);

    // Dwell counter restarts on every state change and saturates once the minimum is met
    always_ff @(posedge clk) begin
        if (reset)
            dcnt <= '0;
        else if (next_state != state)
            dcnt <= '0;
        else if (dcnt != D_LAST)
            dcnt <= dcnt + 1'b1;
    end
`else
    assign dwell_ok = 1'b1;
`endif

    // Next-state decision: bad samples and timeouts go straight to ERROR; good samples
    // move the FSM only once the dwell requirement (if any) is satisfied
    always_comb begin
        next_state = state;
        if (temp_valid) begin
            if (!good) begin
                next_state = ERROR;
            end else if (dwell_ok) begin
                case (state)
                    IDLE: begin
                        if (temp_data < heat_setpoint)
                            next_state = HEATING;
                        else if (temp_data > cool_setpoint)
                            next_state = COOLING;
                    end
                    HEATING: if (temp9 >= heat_thr) next_state = IDLE;
                    COOLING: if (temp9 <= cool_thr) next_state = IDLE;
                    ERROR:   next_state = IDLE;
                    default: next_state = IDLE;
                endcase
            end
        end else if (tcnt == T_LAST) begin
            next_state = ERROR;
        end
    end

    // Sample timeout counter: cleared by any strobe, holds at its terminal value
    always_ff @(posedge clk) begin
        if (reset)
            tcnt <= '0;
        else if (temp_valid)
            tcnt <= '0;
        else if (tcnt != T_LAST)
            tcnt <= tcnt + 1'b1;
    end

    // State register with actuator enables registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            heater_en <= 1'b0;
            cooler_en <= 1'b0;
        end else begin
            state     <= next_state;
            heater_en <= (next_state == HEATING);
            cooler_en <= (next_state == COOLING);
        end
    end

    assign status = state;

endmodule

// File: tb/tb_temp_status_controller.sv
// tb/tb_temp_status_controller.sv - directed bench for temp_status_controller
module tb_temp_status_controller;

    logic       clk;
    logic       reset;
    logic       temp_valid;
    logic [7:0] temp_data;
    logic [7:0] heat_setpoint;
    logic [7:0] cool_setpoint;
    logic [1:0] status;
    logic       heater_en;
    logic       cooler_en;

    int n_cmp;
    int n_bad;

    localparam int G = 12;

    temp_status_controller #(
        .TIMEOUT_CYCLES(20),
        .DWELL_CYCLES  (10),
        .HYST          (2),
        .TEMP_MIN      (0),
        .TEMP_MAX      (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .temp_valid   (temp_valid),
        .temp_data    (temp_data),
        .heat_setpoint(heat_setpoint),
        .cool_setpoint(cool_setpoint),
        .status       (status),
        .heater_en    (heater_en),
        .cooler_en    (cooler_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input logic he, input logic ce);
        check({tag, ".status"}, 8'(status), 8'(st));
        check({tag, ".heater"}, 8'(heater_en), 8'(he));
        check({tag, ".cooler"}, 8'(cooler_en), 8'(ce));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [7:0] d);
        temp_valid = 1'b1;
        temp_data  = d;
        @(posedge clk);
        #1;
        temp_valid = 1'b0;
    endtask

    task automatic step(input int gap, input logic [7:0] d);
        idle(gap);
        sample(d);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        temp_valid = 1'b0;
        temp_data = 8'd0;
        heat_setpoint = 8'd20;
        cool_setpoint = 8'd25;
        idle(3);
        check_out("reset", 2'b00, 1'b0, 1'b0);
        reset = 1'b0;

        step(G, 8'd18);  check_out("heat_enter", 2'b01, 1'b1, 1'b0);
        step(G, 8'd21);  check_out("heat_hold21", 2'b01, 1'b1, 1'b0);
        step(G, 8'd22);  check_out("heat_exit22", 2'b00, 1'b0, 1'b0);

        step(G, 8'd27);  check_out("cool_enter", 2'b10, 1'b0, 1'b1);
        step(G, 8'd24);  check_out("cool_hold24", 2'b10, 1'b0, 1'b1);
        step(G, 8'd23);  check_out("cool_exit23", 2'b00, 1'b0, 1'b0);

        idle(19);        check_out("to_pre", 2'b00, 1'b0, 1'b0);
        idle(1);         check_out("to_error", 2'b11, 1'b0, 1'b0);
        step(G, 8'd22);  check_out("to_recover", 2'b00, 1'b0, 1'b0);

        idle(20);        check_out("to_error2", 2'b11, 1'b0, 1'b0);
        step(G, 8'd18);  check_out("err_to_idle_only", 2'b00, 1'b0, 1'b0);
        step(G, 8'd18);  check_out("heat_again", 2'b01, 1'b1, 1'b0);

        step(G, 8'd101); check_out("bad_101", 2'b11, 1'b0, 1'b0);
        step(G, 8'd22);  check_out("bad_recover", 2'b00, 1'b0, 1'b0);
        step(G, 8'd100); check_out("max_good", 2'b10, 1'b0, 1'b1);
        heat_setpoint = 8'd25;
        step(G, 8'd22);  check_out("bad_setpt", 2'b11, 1'b0, 1'b0);
        heat_setpoint = 8'd20;
        step(G, 8'd22);  check_out("setpt_recover", 2'b00, 1'b0, 1'b0);

        idle(19);
        sample(8'd22);   check_out("expiry_sample", 2'b00, 1'b0, 1'b0);

        heat_setpoint = 8'd0;
        cool_setpoint = 8'd1;
        step(G, 8'd5);   check_out("sat_cool_enter", 2'b10, 1'b0, 1'b1);
        step(G, 8'd1);   check_out("sat_cool_hold", 2'b10, 1'b0, 1'b1);
        step(G, 8'd0);   check_out("sat_cool_exit", 2'b00, 1'b0, 1'b0);
        heat_setpoint = 8'd254;
        cool_setpoint = 8'd255;
        step(G, 8'd50);  check_out("wide_heat_enter", 2'b01, 1'b1, 1'b0);
        step(G, 8'd100); check_out("wide_heat_hold", 2'b01, 1'b1, 1'b0);
        heat_setpoint = 8'd20;
        cool_setpoint = 8'd25;
        step(G, 8'd22);  check_out("wide_heat_exit", 2'b00, 1'b0, 1'b0);

        step(G, 8'd18);  check_out("dwell_enter", 2'b01, 1'b1, 1'b0);
        idle(2);
        sample(8'd30);
`ifdef TEMP_DWELL_EN
        check_out("dwell_early", 2'b01, 1'b1, 1'b0);
        step(G, 8'd30);  check_out("dwell_late", 2'b00, 1'b0, 1'b0);
`else
        check_out("nodwell_early", 2'b00, 1'b0, 1'b0);
`endif

        step(G, 8'd27);  check_out("pre_reset_cool", 2'b10, 1'b0, 1'b1);
        reset = 1'b1;
        temp_valid = 1'b1;
        temp_data = 8'd18;
        @(posedge clk);
        #1;
        reset = 1'b0;
        temp_valid = 1'b0;
        check_out("reset_prio", 2'b00, 1'b0, 1'b0);
        idle(1);         check_out("reset_no_pending", 2'b00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
